ifid_skid_stage: RTL and testbench

//  Parametrised IF->ID pipeline stage register with valid/ready handshake, 2-entry skid

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 49 ++++
 rtl/ifid_skid_stage.sv | 153 +++++++++++++++
 tb/tb_ifid_skid_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF->ID skid stage.
//  - Default widths and the NOP bubble value (sll $0,$0,0 == 32'h0).
//  - Occupancy state encoding for the skid control FSM.
package pipe_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 32;
  localparam int CNT_W_DEF   = 16;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: data register plus valid bit.
// Ports:
//  clk, rst    clock / synchronous active-high reset
//  load        capture d and set valid
//  clear       drop the entry (wins over load)
//  d           data to capture
//  valid       slot holds an entry
//  q           held data
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF->ID pipeline stage with a 2-entry skid buffer (MAIN drives decode,
// SKID catches the entry accepted while decode stalls), flush, and a
// saturating stall-cycle counter.
// Ports:
//  clk, rst              clock / synchronous active-high reset
//  in_valid/in_ready     fetch-side handshake (in_ready is a flop)
//  in_instr, in_pc       fetched instruction and its PC
//  flush                 discard every held and incoming entry
//  out_valid/out_ready   decode-side handshake
//  out_instr, out_pc     to decode; NOP_INSTR / 0 when out_valid=0
//  stall_cnt             cycles with out_valid && !out_ready (saturating)
//  dbg_state             current occupancy state
//
// Handshake: a transfer happens at a rising edge where valid && ready are
// both high; valid never depends on ready, and in_ready has no
// combinational path from out_ready.
module ifid_skid_stage
  import pipe_pkg::*;
#(
  parameter int                   INSTR_W   = INSTR_W_DEF,
  parameter int                   PC_W      = PC_W_DEF,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter int                   CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [1:0]         dbg_state
);

  localparam int DW = INSTR_W + PC_W;

  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic          main_valid, skid_valid;
  logic [DW-1:0] main_data, skid_data, main_din;
  logic          main_load, main_clr, main_from_skid;
  logic          skid_load, skid_clr;
  logic          in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid && out_ready;

  // State register, registered in_ready and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_ONE;
      ST_ONE: begin
        if (in_xfer && !out_xfer)      state_d = ST_TWO;
        else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
      end
      ST_TWO:   if (out_xfer) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Output logic: slot controls, in_ready and counter next values.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    unique case (state_q)
      ST_EMPTY: main_load = in_xfer;
      ST_ONE: begin
        if (in_xfer && out_xfer) main_load = 1'b1;
        else if (in_xfer)        skid_load = 1'b1;
        else if (out_xfer)       main_clr  = 1'b1;
      end
      ST_TWO: begin
        if (out_xfer && skid_valid) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
      end
      default: begin
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end
    endcase
    // Flush drops everything; an accepted input this cycle is discarded.
    if (flush) begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end

    in_ready_d = (state_d != ST_TWO);

    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign main_din = main_from_skid ? skid_data : {in_pc, in_instr};

  pipe_slot #(.W(DW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_din),
    .valid (main_valid),
    .q     (main_data)
  );

  pipe_slot #(.W(DW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     ({in_pc, in_instr}),
    .valid (skid_valid),
    .q     (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_instr = main_valid ? main_data[INSTR_W-1:0] : NOP_INSTR;
  assign out_pc    = main_valid ? main_data[DW-1:INSTR_W] : '0;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
module tb_ifid_skid_stage;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   stall_cnt;
  logic [1:0]         dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ifid_skid_stage #(
    .INSTR_W   (INSTR_W),
    .PC_W      (PC_W),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {pc, instr}; the queue mirrors what the stage should hold.
  logic [63:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic last_rst = 1'b1;
  logic mon_on = 1'b0;
  logic exp_ov, exp_ir;

  always @(negedge clk) begin
    if (mon_on) begin
      exp_ov = (exp_q.size() != 0);
      exp_ir = !last_rst && (exp_q.size() < 2);
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      if (exp_ov) begin
        check_eq("out_instr", {32'd0, out_instr}, {32'd0, exp_q[0][31:0]});
        check_eq("out_pc", {32'd0, out_pc}, {32'd0, exp_q[0][63:32]});
      end else begin
        check_eq("bubble_instr", {32'd0, out_instr}, {32'd0, NOP});
        check_eq("bubble_pc", {32'd0, out_pc}, 64'd0);
      end
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      check_eq("stall_cnt", {60'd0, stall_cnt}, {60'd0, exp_cnt});
      check_eq("dbg_state", {62'd0, dbg_state}, 64'(exp_q.size()));

      // Advance the model to what the next rising edge should do.
      last_rst = rst;
      if (rst) begin
        exp_q.delete();
        exp_cnt = '0;
      end else begin
        if (exp_ov && !out_ready && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        if (exp_ov && out_ready) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (in_valid && exp_ir) exp_q.push_back({in_pc, in_instr});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b0;

    // 1: reset held two cycles
    step(1);
    mon_on = 1'b1;
    step(1);
    check_eq("t1_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t1_out_instr", {32'd0, out_instr}, 64'd0);
    check_eq("t1_in_ready_rst", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    step(1);
    check_eq("t1_in_ready_after", {63'd0, in_ready}, 64'd1);

    // 2: streaming, 1-cycle latency, no gaps
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      present(32'h2008_0000 + 32'(i), 32'h0040_0000 + 32'(4 * i));
      step(1);
      check_eq("t2_stream_instr", {32'd0, out_instr}, {32'd0, 32'h2008_0000 + 32'(i)});
    end
    in_valid = 1'b0;
    step(2);
    check_eq("t2_stall_cnt", {60'd0, stall_cnt}, 64'd0);

    // 3: backpressure into the skid slot
    do_reset();
    out_ready = 1'b0;
    present(32'hA1, 32'h100);
    step(1);
    present(32'hA2, 32'h104);
    step(1);
    check_eq("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
    present(32'hA3, 32'h108);
    step(1);
    check_eq("t3_hold_a1", {32'd0, out_instr}, 64'h0A1);
    step(1);
    out_ready = 1'b1;
    step(1);
    check_eq("t3_out_a2", {32'd0, out_instr}, 64'h0A2);
    step(1);
    check_eq("t3_out_a3", {32'd0, out_instr}, 64'h0A3);
    in_valid = 1'b0;
    step(1);
    check_eq("t3_drained", {63'd0, out_valid}, 64'd0);
    check_eq("t3_stall_cnt", {60'd0, stall_cnt}, 64'd3);

    // 4a: flush while TWO with fetch presenting
    do_reset();
    out_ready = 1'b0;
    present(32'hB1, 32'h200);
    step(1);
    present(32'hB2, 32'h204);
    step(1);
    present(32'hB3, 32'h208);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("t4_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t4_out_instr", {32'd0, out_instr}, {32'd0, NOP});
    check_eq("t4_in_ready", {63'd0, in_ready}, 64'd1);
    step(2);
    check_eq("t4_still_empty", {63'd0, out_valid}, 64'd0);

    // 4b: flush in ONE with an accepted input -> that input is discarded
    present(32'hC1, 32'h300);
    step(1);
    present(32'hC2, 32'h304);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    in_valid = 1'b0;
    step(1);
    check_eq("t4b_discarded", {63'd0, out_valid}, 64'd0);

    // 5: reset with flush while TWO
    do_reset();
    out_ready = 1'b0;
    present(32'hD1, 32'h400);
    step(1);
    present(32'hD2, 32'h404);
    step(2);
    rst = 1'b1;
    flush = 1'b1;
    step(1);
    check_eq("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t5_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("t5_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    in_valid = 1'b0;
    step(1);
    rst = 1'b0;
    flush = 1'b0;
    step(1);
    check_eq("t5_in_ready_after", {63'd0, in_ready}, 64'd1);

    // 6: stall counter saturation
    out_ready = 1'b0;
    present(32'hE1, 32'h500);
    step(1);
    in_valid = 1'b0;
    step(20);
    check_eq("t6_sat", {60'd0, stall_cnt}, 64'd15);
    step(3);
    check_eq("t6_sat_hold", {60'd0, stall_cnt}, 64'd15);

    // random traffic, checked by the scoreboard each cycle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step(1);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    step(4);
    check_eq("final_drained", {63'd0, out_valid}, 64'd0);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
